tcache_tl_arbiter: RTL and testbench

Shares one TileLink Uncached Heavyweight (TL-UH) master port between `NUM_PORTS` texture-cache instances, one per fragment lane. Arbitration is round-robin. A grant is held from A-channel issue until the last D-channel beat of that transaction, so the D channel needs no source IDs. It sits between the texture caches' `tcache_a_*`/`tcache_d_*` ports and the memory interconnect. Only one transaction is outstanding at any time.

---
 rtl/tcache_tl_pkg.sv | 41 ++++
 rtl/tcache_tl_arbiter_rr_pick.sv | 31 +++
 rtl/tcache_tl_arbiter.sv | 169 ++++++++++++++++
 tb/tb_tcache_tl_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcache_tl_pkg.sv
// Shared constants, state encoding and burst helpers for the
// texture-cache TileLink arbiter.
package tcache_tl_pkg;

  localparam logic [2:0] TL_GET          = 3'd4;
  localparam logic [2:0] TL_PUT_FULL     = 3'd0;
  localparam logic [2:0] TL_ACCESS_ACK   = 3'd0;
  localparam logic [2:0] TL_ACCESS_ACK_D = 3'd1;

  localparam int MAX_BURST_LOG2 = 7;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ADDR,
    ARB_DATA
  } arb_state_e;

  function automatic logic req_bad(
    input logic [2:0] op,
    input logic [3:0] size
  );
    logic bad_op;
    logic bad_size;
    bad_op   = (op != TL_GET) && (op != TL_PUT_FULL);
    bad_size = size > 4'(MAX_BURST_LOG2);
    return bad_op || bad_size ||
           ((op == TL_PUT_FULL) && (size > 4'd2));
  endfunction

  // Data bus is 4 bytes wide, so a Get needs 2^(size-2) D beats.
  function automatic logic [5:0] beat_count(
    input logic [2:0] op,
    input logic [3:0] size
  );
    if (req_bad(op, size) || (op == TL_PUT_FULL) ||
        (size <= 4'd2))
      return 6'd1;
    return 6'd1 << (size - 4'd2);
  endfunction

endpackage

// File: rtl/tcache_tl_arbiter_rr_pick.sv
// Combinational round-robin picker: first request at or after
// the pointer, scanning upward modulo the port count.
module tc_rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  int pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = 0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(ptr) + k) % N;
      if (!any && req[pos]) begin
        any        = 1'b1;
        grant[pos] = 1'b1;
        idx        = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/tcache_tl_arbiter.sv
// Round-robin sharing of one TL-UH master port between texture
// caches; grant held from A issue to the last D beat.
module tcache_tl_arbiter
  import tcache_tl_pkg::*;
#(
  parameter int NUM_PORTS = 4
) (
  input  logic                   core_clock_i,
  input  logic                   core_reset_i,
  input  logic [3*NUM_PORTS-1:0] req_a_opcode_i,
  input  logic [3*NUM_PORTS-1:0] req_a_param_i,
  input  logic [4*NUM_PORTS-1:0] req_a_size_i,
  input  logic [32*NUM_PORTS-1:0] req_a_address_i,
  input  logic [4*NUM_PORTS-1:0] req_a_mask_i,
  input  logic [32*NUM_PORTS-1:0] req_a_data_i,
  input  logic [NUM_PORTS-1:0]   req_a_corrupt_i,
  input  logic [NUM_PORTS-1:0]   req_a_valid_i,
  output logic [NUM_PORTS-1:0]   req_a_ready_o,
  output logic [2:0]             req_d_opcode_o,
  output logic [1:0]             req_d_param_o,
  output logic [3:0]             req_d_size_o,
  output logic                   req_d_denied_o,
  output logic [31:0]            req_d_data_o,
  output logic                   req_d_corrupt_o,
  output logic [NUM_PORTS-1:0]   req_d_valid_o,
  input  logic [NUM_PORTS-1:0]   req_d_ready_i,
  output logic [2:0]             tl_a_opcode_o,
  output logic [2:0]             tl_a_param_o,
  output logic [3:0]             tl_a_size_o,
  output logic [31:0]            tl_a_address_o,
  output logic [3:0]             tl_a_mask_o,
  output logic [31:0]            tl_a_data_o,
  output logic                   tl_a_corrupt_o,
  output logic                   tl_a_valid_o,
  input  logic                   tl_a_ready_i,
  input  logic [2:0]             tl_d_opcode_i,
  input  logic [1:0]             tl_d_param_i,
  input  logic [3:0]             tl_d_size_i,
  input  logic                   tl_d_denied_i,
  input  logic [31:0]            tl_d_data_i,
  input  logic                   tl_d_corrupt_i,
  input  logic                   tl_d_valid_i,
  output logic                   tl_d_ready_o,
  output logic                   protocol_err_o
);

  localparam int IW = $clog2(NUM_PORTS);

  arb_state_e state_q, state_d;

  logic [IW-1:0]        rr_ptr;
  logic [IW-1:0]        owner;
  logic [5:0]           beats_left;
  logic [NUM_PORTS-1:0] win_grant;
  logic [IW-1:0]        win_idx;
  logic                 win_any;
  logic                 take;
  logic                 active;
  logic                 d_hs;
  logic                 done;
  logic [IW-1:0]        next_ptr;

  logic [2:0]  w_opcode;
  logic [2:0]  w_param;
  logic [3:0]  w_size;
  logic [31:0] w_address;
  logic [3:0]  w_mask;
  logic [31:0] w_data;
  logic        w_corrupt;

  tc_rr_pick #(
    .N  (NUM_PORTS),
    .IW (IW)
  ) u_pick (
    .req   (req_a_valid_i),
    .ptr   (rr_ptr),
    .grant (win_grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  assign w_opcode  = req_a_opcode_i[int'(win_idx)*3 +: 3];
  assign w_param   = req_a_param_i[int'(win_idx)*3 +: 3];
  assign w_size    = req_a_size_i[int'(win_idx)*4 +: 4];
  assign w_address = req_a_address_i[int'(win_idx)*32 +: 32];
  assign w_mask    = req_a_mask_i[int'(win_idx)*4 +: 4];
  assign w_data    = req_a_data_i[int'(win_idx)*32 +: 32];
  assign w_corrupt = req_a_corrupt_i[win_idx];

  assign active = (state_q != ARB_IDLE) && !core_reset_i;
  assign take   = (state_q == ARB_IDLE) && win_any;

  assign req_a_ready_o = (take && !core_reset_i) ? win_grant : '0;
  assign tl_a_valid_o  = (state_q == ARB_ADDR);

  assign tl_d_ready_o = active && req_d_ready_i[owner];
  assign d_hs         = tl_d_valid_i && tl_d_ready_o;
  assign done         = d_hs && (beats_left == 6'd1);

  assign next_ptr = (owner == IW'(NUM_PORTS - 1)) ?
                    '0 : owner + IW'(1);

  assign req_d_opcode_o  = tl_d_opcode_i;
  assign req_d_param_o   = tl_d_param_i;
  assign req_d_size_o    = tl_d_size_i;
  assign req_d_denied_o  = tl_d_denied_i;
  assign req_d_data_o    = tl_d_data_i;
  assign req_d_corrupt_o = tl_d_corrupt_i;

  always_comb begin
    req_d_valid_o = '0;
    if (active)
      req_d_valid_o[owner] = tl_d_valid_i;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: if (win_any) state_d = ARB_ADDR;
      ARB_ADDR: begin
        // A D beat can finish a short transaction before DATA.
        if (done)              state_d = ARB_IDLE;
        else if (tl_a_ready_i) state_d = ARB_DATA;
      end
      ARB_DATA: if (done) state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge core_clock_i) begin
    if (core_reset_i) state_q <= ARB_IDLE;
    else              state_q <= state_d;
  end

  always_ff @(posedge core_clock_i) begin
    if (core_reset_i) begin
      rr_ptr         <= '0;
      owner          <= '0;
      beats_left     <= '0;
      tl_a_opcode_o  <= '0;
      tl_a_param_o   <= '0;
      tl_a_size_o    <= '0;
      tl_a_address_o <= '0;
      tl_a_mask_o    <= '0;
      tl_a_data_o    <= '0;
      tl_a_corrupt_o <= 1'b0;
      protocol_err_o <= 1'b0;
    end else begin
      if (take) begin
        owner          <= win_idx;
        beats_left     <= beat_count(w_opcode, w_size);
        tl_a_opcode_o  <= w_opcode;
        tl_a_param_o   <= w_param;
        tl_a_size_o    <= w_size;
        tl_a_address_o <= w_address;
        tl_a_mask_o    <= w_mask;
        tl_a_data_o    <= w_data;
        tl_a_corrupt_o <= w_corrupt;
        if (req_bad(w_opcode, w_size))
          protocol_err_o <= 1'b1;
      end else if (d_hs) begin
        beats_left <= beats_left - 6'd1;
      end
      if (done)
        rr_ptr <= next_ptr;
    end
  end

endmodule

// File: tb/tb_tcache_tl_arbiter.sv
// Directed bench for tcache_tl_arbiter with hand-computed
// expectations for grants, forwarding and D-beat routing.
module tb_tcache_tl_arbiter;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [3*N-1:0]  a_opcode;
  logic [3*N-1:0]  a_param;
  logic [4*N-1:0]  a_size;
  logic [32*N-1:0] a_address;
  logic [4*N-1:0]  a_mask;
  logic [32*N-1:0] a_data;
  logic [N-1:0]    a_corrupt;
  logic [N-1:0]    a_valid;
  logic [N-1:0]    a_ready;
  logic [2:0]      rd_opcode;
  logic [1:0]      rd_param;
  logic [3:0]      rd_size;
  logic            rd_denied;
  logic [31:0]     rd_data;
  logic            rd_corrupt;
  logic [N-1:0]    rd_valid;
  logic [N-1:0]    rd_ready;
  logic [2:0]      ta_opcode;
  logic [2:0]      ta_param;
  logic [3:0]      ta_size;
  logic [31:0]     ta_address;
  logic [3:0]      ta_mask;
  logic [31:0]     ta_data;
  logic            ta_corrupt;
  logic            ta_valid;
  logic            ta_ready;
  logic [2:0]      td_opcode;
  logic [1:0]      td_param;
  logic [3:0]      td_size;
  logic            td_denied;
  logic [31:0]     td_data;
  logic            td_corrupt;
  logic            td_valid;
  logic            td_ready;
  logic            perr;

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  tcache_tl_arbiter #(.NUM_PORTS(N)) dut (
    .core_clock_i    (clk),
    .core_reset_i    (rst),
    .req_a_opcode_i  (a_opcode),
    .req_a_param_i   (a_param),
    .req_a_size_i    (a_size),
    .req_a_address_i (a_address),
    .req_a_mask_i    (a_mask),
    .req_a_data_i    (a_data),
    .req_a_corrupt_i (a_corrupt),
    .req_a_valid_i   (a_valid),
    .req_a_ready_o   (a_ready),
    .req_d_opcode_o  (rd_opcode),
    .req_d_param_o   (rd_param),
    .req_d_size_o    (rd_size),
    .req_d_denied_o  (rd_denied),
    .req_d_data_o    (rd_data),
    .req_d_corrupt_o (rd_corrupt),
    .req_d_valid_o   (rd_valid),
    .req_d_ready_i   (rd_ready),
    .tl_a_opcode_o   (ta_opcode),
    .tl_a_param_o    (ta_param),
    .tl_a_size_o     (ta_size),
    .tl_a_address_o  (ta_address),
    .tl_a_mask_o     (ta_mask),
    .tl_a_data_o     (ta_data),
    .tl_a_corrupt_o  (ta_corrupt),
    .tl_a_valid_o    (ta_valid),
    .tl_a_ready_i    (ta_ready),
    .tl_d_opcode_i   (td_opcode),
    .tl_d_param_i    (td_param),
    .tl_d_size_i     (td_size),
    .tl_d_denied_i   (td_denied),
    .tl_d_data_i     (td_data),
    .tl_d_corrupt_i  (td_corrupt),
    .tl_d_valid_i    (td_valid),
    .tl_d_ready_o    (td_ready),
    .protocol_err_o  (perr)
  );

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(
    input int          p,
    input logic [2:0]  op,
    input logic [3:0]  sz,
    input logic [31:0] addr,
    input logic [31:0] data,
    input logic [3:0]  mask
  );
    a_opcode[p*3 +: 3]   = op;
    a_param[p*3 +: 3]    = 3'd0;
    a_size[p*4 +: 4]     = sz;
    a_address[p*32 +: 32] = addr;
    a_data[p*32 +: 32]   = data;
    a_mask[p*4 +: 4]     = mask;
    a_corrupt[p]         = 1'b0;
    a_valid[p]           = 1'b1;
  endtask

  int hs;
  int good;
  int low;
  int cyc;
  int stable;
  int order [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst = 1'b1;
    a_opcode = '0; a_param = '0; a_size = '0;
    a_address = '0; a_mask = '0; a_data = '0;
    a_corrupt = '0; a_valid = '0;
    rd_ready = '0; ta_ready = 1'b0;
    td_opcode = '0; td_param = '0; td_size = '0;
    td_denied = 1'b0; td_data = '0; td_corrupt = 1'b0;
    td_valid = 1'b0;
    step();
    step();

    // Handshake outputs gated while reset is high
    a_valid  = 4'b1111;
    td_valid = 1'b1;
    rd_ready = 4'hF;
    #1;
    chk("rst_a_ready", a_ready, 4'b0000);
    chk("rst_d_ready", td_ready, 1'b0);
    chk("rst_d_valid", rd_valid, 4'b0000);
    a_valid  = '0;
    td_valid = 1'b0;
    step();
    rst = 1'b0;
    chk("rst_a_valid", ta_valid, 1'b0);
    chk("rst_a_addr", ta_address, 32'h0);
    chk("rst_a_opc", ta_opcode, 3'd0);
    chk("rst_perr", perr, 1'b0);

    // T1: requester 1 Get size 7, 32 beats
    set_req(1, 3'd4, 4'd7, 32'h8000_0080, 32'h0, 4'hF);
    #1;
    chk("t1_ready", a_ready, 4'b0010);
    step();
    a_valid = '0;
    #1;
    chk("t1_a_valid", ta_valid, 1'b1);
    chk("t1_a_addr", ta_address, 32'h8000_0080);
    chk("t1_a_size", ta_size, 4'd7);
    chk("t1_a_opc", ta_opcode, 3'd4);
    chk("t1_a_mask", ta_mask, 4'hF);
    chk("t1_no_regrant", a_ready, 4'b0000);
    ta_ready = 1'b1;
    step();
    ta_ready = 1'b0;
    #1;
    chk("t1_a_drop", ta_valid, 1'b0);
    hs = 0; good = 0; cyc = 0;
    td_opcode = 3'd1;
    while (hs < 32 && cyc < 60) begin
      td_valid = 1'b1;
      td_data  = 32'(hs) + 32'h100;
      #1;
      if (td_ready) begin
        if (rd_valid === 4'b0010 && rd_data === 32'(hs) + 32'h100)
          good++;
        hs++;
      end
      step();
      cyc++;
    end
    chk("t1_beats", good, 32);
    #1;
    chk("t1_idle_dready", td_ready, 1'b0);
    chk("t1_idle_dvalid", rd_valid, 4'b0000);
    td_valid = 1'b0;
    set_req(0, 3'd4, 4'd2, 32'h0, 32'h0, 4'hF);
    set_req(2, 3'd4, 4'd2, 32'h0, 32'h0, 4'hF);
    #1;
    chk("t1_rr_ptr", a_ready, 4'b0100);
    a_valid = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;

    // T2: all four hold Gets size 2 continuously
    for (int p = 0; p < N; p++)
      set_req(p, 3'd4, 4'd2, 32'h100 * p, 32'h0, 4'hF);
    for (int t = 0; t < 5; t++) begin
      #1;
      chk($sformatf("t2_grant%0d", t), a_ready,
          64'(1) << order[t]);
      step();
      ta_ready = 1'b1;
      if (t == 4) td_valid = 1'b1;
      #1;
      chk($sformatf("t2_busyA%0d", t), a_ready, 4'b0000);
      step();
      ta_ready = 1'b0;
      if (t < 4) begin
        td_valid = 1'b1;
        #1;
        chk($sformatf("t2_busyD%0d", t), a_ready, 4'b0000);
        chk($sformatf("t2_dvalid%0d", t), rd_valid,
            64'(1) << order[t]);
        step();
        td_valid = 1'b0;
      end else begin
        td_valid = 1'b0;
        #1;
        chk("t2_addr_beat", a_ready, 4'b0010);
      end
    end
    a_valid = '0;
    step();

    // T3: requester 2 PutFullData with A-ready stall
    set_req(2, 3'd0, 4'd2, 32'h2000_0040, 32'hDEAD_BEEF, 4'hF);
    #1;
    chk("t3_ready", a_ready, 4'b0100);
    step();
    a_valid = '0;
    stable = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (ta_valid && ta_address == 32'h2000_0040 &&
          ta_data == 32'hDEAD_BEEF && ta_mask == 4'hF &&
          ta_opcode == 3'd0 && ta_size == 4'd2)
        stable++;
      step();
    end
    chk("t3_stall", stable, 5);
    ta_ready = 1'b1;
    #1;
    chk("t3_a_data", ta_data, 32'hDEAD_BEEF);
    step();
    ta_ready = 1'b0;
    #1;
    chk("t3_to_data", ta_valid, 1'b0);
    td_opcode = 3'd0;
    td_valid  = 1'b1;
    #1;
    chk("t3_ack_route", rd_valid, 4'b0100);
    chk("t3_ack_opc", rd_opcode, 3'd0);
    step();
    #1;
    chk("t3_done", td_ready, 1'b0);
    chk("t3_no_err", perr, 1'b0);
    td_valid = 1'b0;

    // T4: owner 0 drops D ready for 3 cycles mid-burst
    set_req(0, 3'd4, 4'd7, 32'h3000_0000, 32'h0, 4'hF);
    #1;
    chk("t4_ready", a_ready, 4'b0001);
    step();
    a_valid  = '0;
    ta_ready = 1'b1;
    step();
    ta_ready = 1'b0;
    hs = 0; low = 0; cyc = 0;
    td_opcode = 3'd1;
    while (hs < 32 && cyc < 60) begin
      td_valid = 1'b1;
      rd_ready = (cyc >= 10 && cyc < 13) ? 4'b1110 : 4'b1111;
      #1;
      if (td_ready) hs++;
      else          low++;
      step();
      cyc++;
    end
    rd_ready = 4'hF;
    chk("t4_low", low, 3);
    chk("t4_beats", hs, 32);
    chk("t4_cycles", cyc, 35);
    #1;
    chk("t4_idle", td_ready, 1'b0);
    td_valid = 1'b0;

    // T5: PutFullData size 4 is unsupported
    set_req(3, 3'd0, 4'd4, 32'h5000_0000, 32'h1234_5678, 4'hF);
    #1;
    chk("t5_ready", a_ready, 4'b1000);
    step();
    a_valid = '0;
    #1;
    chk("t5_err", perr, 1'b1);
    chk("t5_fwd_size", ta_size, 4'd4);
    ta_ready = 1'b1;
    step();
    ta_ready  = 1'b0;
    td_opcode = 3'd0;
    td_valid  = 1'b1;
    #1;
    chk("t5_beat", td_ready, 1'b1);
    step();
    #1;
    chk("t5_one_beat", td_ready, 1'b0);
    chk("t5_err_held", perr, 1'b1);
    td_valid = 1'b0;

    // T6: reset during beat 10 of a Get
    set_req(1, 3'd4, 4'd7, 32'h4000_0000, 32'h0, 4'hF);
    step();
    a_valid  = '0;
    ta_ready = 1'b1;
    step();
    ta_ready  = 1'b0;
    td_opcode = 3'd1;
    td_valid  = 1'b1;
    hs = 0;
    for (int b = 0; b < 9; b++) begin
      #1;
      if (td_ready) hs++;
      step();
    end
    chk("t6_pre_beats", hs, 9);
    rst = 1'b1;
    #1;
    chk("t6_rst_dready", td_ready, 1'b0);
    chk("t6_rst_dvalid", rd_valid, 4'b0000);
    step();
    rst      = 1'b0;
    td_valid = 1'b0;
    #1;
    chk("t6_a_valid", ta_valid, 1'b0);
    chk("t6_a_addr", ta_address, 32'h0);
    chk("t6_err_clr", perr, 1'b0);
    chk("t6_idle_dready", td_ready, 1'b0);
    chk("t6_a_ready", a_ready, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

endmodule
